// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: shares one 16x4 asynchronous SRAM between two
// requesters. One request is latched at a time and played out on the memory
// pins as SETUP -> STROBE -> HOLD, then completed with a one-cycle response
// strobe to its owner.
// Optional build macro: MEM_ARB_FIXED_PRIO_EN (requester 0 always wins
// contention; no last-grant pointer). Default is round-robin.
module mem_access_arbiter #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 4,
    parameter int SETUP_CYC  = 1,   // 1..7
    parameter int STROBE_CYC = 2    // 1..7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              mem_cs_n,
    output logic              mem_we_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t            state, state_nxt;
    logic [2:0]        cnt, cnt_nxt;
    logic              grant;      // 0 = requester 0, 1 = requester 1
    logic              accept;
    logic              lat_we;
    logic              owner;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

`ifdef MEM_ARB_FIXED_PRIO_EN
    // Requester 0 wins whenever it is asking.
    always_comb begin
        grant = ~req0_valid & req1_valid;
    end
`else
    logic last_grant;

    // Lone requester wins; on contention the one not served last wins.
    always_comb begin
        if (req0_valid && req1_valid) grant = ~last_grant;
        else                          grant = req1_valid;
    end

    // Remember who was served last; reset value 1 lets requester 0 win first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      last_grant <= 1'b1;
        else if (accept) last_grant <= grant;
    end
`endif

    assign req0_ready = (state == IDLE) & ~grant;
    assign req1_ready = (state == IDLE) &  grant;
    assign accept     = grant ? (req1_valid & req1_ready) : (req0_valid & req0_ready);

    // Capture the accepted request; it drives the memory pins until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples pre-edge values regardless of process evaluation order.
            lat_we    <= 1'b0;
            owner     <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (accept) begin
            lat_we    <= grant ? req1_we    : req0_we;
            owner     <= grant;
            lat_addr  <= grant ? req1_addr  : req0_addr;
            lat_wdata <= grant ? req1_wdata : req0_wdata;
        end
    end

    // State and phase-counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state, phase countdown and memory/response strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_nxt  = state;
        cnt_nxt    = cnt;
        mem_cs_n   = 1'b0;
        mem_we_n   = 1'b1;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        case (state)
            IDLE: begin
                mem_cs_n = 1'b1;
                if (accept) begin
                    state_nxt = SETUP;
                    cnt_nxt   = 3'(SETUP_CYC - 1);
                end
            end
            SETUP: begin
                if (cnt == 3'd0) begin
                    state_nxt = STROBE;
                    cnt_nxt   = 3'(STROBE_CYC - 1);
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            STROBE: begin
                mem_we_n = ~lat_we;
                if (cnt == 3'd0) state_nxt = HOLD;
                else             cnt_nxt   = cnt - 3'd1;
            end
            HOLD: begin
                rsp0_valid = ~owner;
                rsp1_valid =  owner;
                state_nxt  = IDLE;
            end
            default: begin
                mem_cs_n  = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

    // Read data is sampled on the last strobe cycle into the owner's register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_rdata <= '0;
            rsp1_rdata <= '0;
        end else if (state == STROBE && cnt == 3'd0 && !lat_we) begin
            if (owner) rsp1_rdata <= mem_rdata;
            else       rsp0_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Testbench for mem_access_arbiter: default-parameter instance with an SRAM
// model and response scoreboard, plus a SETUP_CYC=3/STROBE_CYC=1 instance.
`timescale 1ns/1ps
module tb_mem_access_arbiter;

    localparam int SETUP  = 1;
    localparam int STROBE = 2;
    localparam int LAT    = SETUP + STROBE + 1;
    localparam int GAP    = SETUP + STROBE + 2;

    typedef logic [3:0] mem_t [16];
    typedef struct { logic we; logic [3:0] rdata; int cyc; } exp_t;
    typedef struct { int id; logic we; logic [3:0] addr; logic [3:0] wdata; logic [3:0] exp_rd; } vec_t;

    function automatic mem_t init_pat();
        mem_t m;
        for (int i = 0; i < 16; i++) m[i] = 4'((i * 7 + 3) & 15);
        return m;
    endfunction

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Default instance signals
    logic       req0_valid, req0_ready, req0_we, rsp0_valid;
    logic [3:0] req0_addr, req0_wdata, rsp0_rdata;
    logic       req1_valid, req1_ready, req1_we, rsp1_valid;
    logic [3:0] req1_addr, req1_wdata, rsp1_rdata;
    logic       mem_cs_n, mem_we_n;
    logic [3:0] mem_addr, mem_wdata, mem_rdata;

    mem_access_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .mem_cs_n(mem_cs_n), .mem_we_n(mem_we_n), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_t sram = init_pat();
    assign mem_rdata = (!mem_cs_n && mem_we_n) ? sram[mem_addr] : 4'h0;
    always @(posedge clk) if (!mem_cs_n && !mem_we_n) sram[mem_addr] <= mem_wdata;

    // Timing-parameter instance signals
    logic       t_req0_valid, t_req0_ready, t_req0_we, t_rsp0_valid;
    logic [3:0] t_req0_addr, t_req0_wdata, t_rsp0_rdata;
    logic       t_req1_valid, t_req1_ready, t_req1_we, t_rsp1_valid;
    logic [3:0] t_req1_addr, t_req1_wdata, t_rsp1_rdata;
    logic       t_mem_cs_n, t_mem_we_n;
    logic [3:0] t_mem_addr, t_mem_wdata, t_mem_rdata;

    mem_access_arbiter #(.SETUP_CYC(3), .STROBE_CYC(1)) dut_t (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(t_req0_valid), .req0_ready(t_req0_ready), .req0_we(t_req0_we),
        .req0_addr(t_req0_addr), .req0_wdata(t_req0_wdata),
        .rsp0_valid(t_rsp0_valid), .rsp0_rdata(t_rsp0_rdata),
        .req1_valid(t_req1_valid), .req1_ready(t_req1_ready), .req1_we(t_req1_we),
        .req1_addr(t_req1_addr), .req1_wdata(t_req1_wdata),
        .rsp1_valid(t_rsp1_valid), .rsp1_rdata(t_rsp1_rdata),
        .mem_cs_n(t_mem_cs_n), .mem_we_n(t_mem_we_n), .mem_addr(t_mem_addr),
        .mem_wdata(t_mem_wdata), .mem_rdata(t_mem_rdata)
    );

    mem_t t_sram = init_pat();
    assign t_mem_rdata = (!t_mem_cs_n && t_mem_we_n) ? t_sram[t_mem_addr] : 4'h0;
    always @(posedge clk) if (!t_mem_cs_n && !t_mem_we_n) t_sram[t_mem_addr] <= t_mem_wdata;

    // Bench state
    int   n_pass = 0;
    int   n_total = 0;
    exp_t q0[$];
    exp_t q1[$];
    mem_t ref_mem = init_pat();
    logic [3:0] model_rd [2] = '{4'h0, 4'h0};
    int   accept_log[$];
    int   last_accept [2] = '{0, 0};
    int   rsp_cnt = 0;
    int   viol = 0;
    int   we_start = 0, we_run = 0;
    logic [3:0] we_addr = 4'h0, we_wdata = 4'h0;
    int   t_we_start = 0, t_we_run = 0, t_rsp_cyc = 0, t_rsp_n = 0, t_viol = 0;
    logic [3:0] t_rsp_data = 4'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic drive(input int id, input logic v, input logic we,
                         input logic [3:0] a, input logic [3:0] d);
        if (id == 0) begin
            req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
        end
    endtask

    // Present one request, wait for acceptance, push its expected response.
    task automatic issue(input int id, input logic we, input logic [3:0] addr,
                         input logic [3:0] wdata, input bit has_exp, input logic [3:0] exp_rd);
        bit   got = 1'b0;
        exp_t e;
        @(negedge clk);
        drive(id, 1'b1, we, addr, wdata);
        for (int k = 0; k < 60 && !got; k++) begin
            #1;
            if ((id == 0) ? req0_ready : req1_ready) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) begin
            check($sformatf("req%0d_accept_timeout", id), 0, 1);
            drive(id, 1'b0, we, addr, wdata);
            return;
        end
        e.we  = we;
        e.cyc = cyc + LAT;
        if (we) begin
            ref_mem[addr] = wdata;
            e.rdata = model_rd[id];
        end else begin
            e.rdata = has_exp ? exp_rd : ref_mem[addr];
            model_rd[id] = e.rdata;
        end
        if (id == 0) q0.push_back(e);
        else         q1.push_back(e);
        accept_log.push_back(id);
        last_accept[id] = cyc;
        @(posedge clk);
        #1;
        drive(id, 1'b0, we, addr, wdata);
    endtask

    task automatic take_rsp(input int id, input logic [3:0] rdata);
        exp_t e;
        rsp_cnt++;
        if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
            check($sformatf("rsp%0d_unexpected", id), 1, 0);
        end else begin
            if (id == 0) e = q0.pop_front();
            else         e = q1.pop_front();
            check($sformatf("rsp%0d_cycle", id), cyc, e.cyc);
            check($sformatf("rsp%0d_rdata_%s", id, e.we ? "wr" : "rd"), rdata, e.rdata);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((q0.size() != 0 || q1.size() != 0) && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (k >= 200) check("idle_timeout", 0, 1);
        @(negedge clk);
        #1;
    endtask

    // Response scoreboard and memory-pin protocol monitor, default instance.
    initial begin
        logic       prev_low = 1'b0;
        logic [3:0] prev_addr = 4'h0, prev_wdata = 4'h0;
        forever begin
            @(negedge clk);
            if (rsp0_valid) take_rsp(0, rsp0_rdata);
            if (rsp1_valid) take_rsp(1, rsp1_rdata);
            if (req0_ready && req1_ready) viol++;
            if (!mem_we_n) begin
                if (mem_cs_n) viol++;
                if (prev_low && (mem_addr !== prev_addr || mem_wdata !== prev_wdata)) viol++;
                if (!prev_low) begin
                    we_start = cyc;
                    we_run   = 0;
                end
                we_run++;
                we_addr  = mem_addr;
                we_wdata = mem_wdata;
            end
            prev_low   = !mem_we_n;
            prev_addr  = mem_addr;
            prev_wdata = mem_wdata;
        end
    end

    // Monitor for the timing-parameter instance.
    initial begin
        logic prev_low = 1'b0;
        forever begin
            @(negedge clk);
            if (!t_mem_we_n) begin
                if (t_mem_cs_n) t_viol++;
                if (!prev_low) begin
                    t_we_start = cyc;
                    t_we_run   = 0;
                end
                t_we_run++;
            end
            prev_low = !t_mem_we_n;
            if (t_rsp0_valid) begin
                t_rsp_cyc  = cyc;
                t_rsp_data = t_rsp0_rdata;
                t_rsp_n++;
            end
            if (t_rsp1_valid) t_viol++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [9];
        int   exp_order [4];
        int   n0, t0, ga;

        tbl[0] = '{0, 1'b1, 4'h5, 4'hA, 4'h0};
        tbl[1] = '{0, 1'b0, 4'h5, 4'h0, 4'hA};
        tbl[2] = '{1, 1'b1, 4'hF, 4'h3, 4'h0};
        tbl[3] = '{1, 1'b1, 4'h0, 4'hC, 4'h0};
        tbl[4] = '{0, 1'b0, 4'hF, 4'h0, 4'h3};
        tbl[5] = '{1, 1'b0, 4'h0, 4'h0, 4'hC};
        tbl[6] = '{1, 1'b0, 4'h5, 4'h0, 4'hA};
        tbl[7] = '{0, 1'b1, 4'h5, 4'h6, 4'h0};
        tbl[8] = '{0, 1'b0, 4'h5, 4'h0, 4'h6};
`ifdef MEM_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 1, 1};
`else
        exp_order = '{0, 1, 0, 1};
`endif

        drive(0, 1'b0, 1'b0, 4'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 4'h0, 4'h0);
        t_req0_valid = 1'b0; t_req0_we = 1'b0; t_req0_addr = 4'h0; t_req0_wdata = 4'h0;
        t_req1_valid = 1'b0; t_req1_we = 1'b0; t_req1_addr = 4'h0; t_req1_wdata = 4'h0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cs_n", mem_cs_n, 1);
        check("rst_we_n", mem_we_n, 1);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_rsp0_valid", rsp0_valid, 0);
        check("rst_rsp1_valid", rsp1_valid, 0);
        check("rst_rsp0_rdata", rsp0_rdata, 0);
        check("rst_rsp1_rdata", rsp1_rdata, 0);
        check("rst_t_cs_n", t_mem_cs_n, 1);
        check("rst_t_rsp1_rdata", t_rsp1_rdata, 0);
        check("idle_t_req1_ready", t_req1_ready, 0);
        rst_n = 1'b1;

        // Contention right after reset: two reads from each requester
        accept_log.delete();
        fork
            begin
                issue(0, 1'b0, 4'h2, 4'h0, 1'b0, 4'h0);
                issue(0, 1'b0, 4'h3, 4'h0, 1'b0, 4'h0);
            end
            begin
                issue(1, 1'b0, 4'hB, 4'h0, 1'b0, 4'h0);
                issue(1, 1'b0, 4'hC, 4'h0, 1'b0, 4'h0);
            end
        join
        wait_idle();
        check("contention_count", accept_log.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("grant_order_%0d", i),
                  (i < accept_log.size()) ? accept_log[i] : 99, exp_order[i]);

        // Table-driven single transactions (write/read-back, boundary addresses)
        for (int i = 0; i < 9; i++) begin
            issue(tbl[i].id, tbl[i].we, tbl[i].addr, tbl[i].wdata, 1'b1, tbl[i].exp_rd);
            wait_idle();
            if (i == 0) begin
                check("we_low_cycles", we_run, STROBE);
                check("we_addr", we_addr, 4'h5);
                check("we_wdata", we_wdata, 4'hA);
                check("we_start", we_start, last_accept[0] + SETUP + 1);
            end
        end

        // Back-to-back requests from one requester: served every slot
        issue(1, 1'b1, 4'h8, 4'h7, 1'b1, 4'h0);
        ga = last_accept[1];
        issue(1, 1'b0, 4'h8, 4'h0, 1'b1, 4'h7);
        check("b2b_gap_1", last_accept[1] - ga, GAP);
        ga = last_accept[1];
        issue(1, 1'b0, 4'hF, 4'h0, 1'b1, 4'h3);
        check("b2b_gap_2", last_accept[1] - ga, GAP);
        wait_idle();

        // Reset during the strobe of a write
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 4'h9, 4'h1);
        #1;
        check("midrst_ready", req0_ready, 1);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b1, 4'h9, 4'h1);
        n0 = rsp_cnt;
        @(posedge clk);
        #2;
        check("midrst_we_low_before", mem_we_n, 0);
        rst_n = 1'b0;
        #1;
        check("midrst_we_n", mem_we_n, 1);
        check("midrst_cs_n", mem_cs_n, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_rd = '{4'h0, 4'h0};
        repeat (6) @(negedge clk);
        #1;
        check("midrst_no_rsp", rsp_cnt, n0);
        issue(0, 1'b1, 4'h9, 4'h5, 1'b1, 4'h0);
        issue(0, 1'b0, 4'h9, 4'h0, 1'b1, 4'h5);
        wait_idle();
        check("protocol_violations", viol, 0);

        // SETUP_CYC=3, STROBE_CYC=1 instance: write then read back
        @(negedge clk);
        t_req0_valid = 1'b1; t_req0_we = 1'b1; t_req0_addr = 4'h7; t_req0_wdata = 4'h9;
        #1;
        check("t_wr_ready", t_req0_ready, 1);
        t0 = cyc;
        n0 = t_rsp_n;
        @(posedge clk);
        #1;
        t_req0_valid = 1'b0;
        for (int k = 0; k < 20 && t_rsp_n == n0; k++) begin
            @(negedge clk);
            #1;
        end
        check("t_wr_rsp_seen", t_rsp_n, n0 + 1);
        check("t_wr_rsp_cycle", t_rsp_cyc, t0 + 5);
        check("t_we_start", t_we_start, t0 + 4);
        check("t_we_cycles", t_we_run, 1);

        @(negedge clk);
        t_req0_valid = 1'b1; t_req0_we = 1'b0; t_req0_addr = 4'h7; t_req0_wdata = 4'h0;
        #1;
        check("t_rd_ready", t_req0_ready, 1);
        t0 = cyc;
        n0 = t_rsp_n;
        @(posedge clk);
        #1;
        t_req0_valid = 1'b0;
        for (int k = 0; k < 20 && t_rsp_n == n0; k++) begin
            @(negedge clk);
            #1;
        end
        check("t_rd_rsp_seen", t_rsp_n, n0 + 1);
        check("t_rd_rsp_cycle", t_rsp_cyc, t0 + 5);
        check("t_rd_rdata", t_rsp_data, 4'h9);
        check("t_protocol_violations", t_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
